// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS constants, opcode/funct encodings and PC helpers.
package mips_pkg;
    localparam int          INST_W   = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        SEL_RESET,
        SEL_REDIRECT,
        SEL_SEQ,
        SEL_HOLD
    } pc_sel_e;

    // Instructions are word aligned; stray low address bits are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & ~32'h3;
    endfunction
endpackage

// File: rtl/fetch_pc_next.sv
// fetch_pc_next: next-PC selection (reset > redirect > sequential > hold).
module fetch_pc_next
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        load,
    input  logic [31:0] pc,
    output logic [31:0] pc_next
);
    pc_sel_e sel;

    always_comb begin
        sel     = rst ? SEL_RESET : redirect_valid ? SEL_REDIRECT : load ? SEL_SEQ : SEL_HOLD;
        pc_next = sel == SEL_RESET    ? align_pc(RESET_PC) :
                  sel == SEL_REDIRECT ? align_pc(redirect_target) :
                  sel == SEL_SEQ      ? pc + 32'd4 : pc;
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC register, ROM addressing and IF/ID output register with
// valid/ready handoff, redirect flush and handoff counter.
module inst_fetch
    import mips_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_inst,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_pc_plus4,
    output logic [31:0]       fetch_count
);
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        load;
    logic        handoff;

    assign load     = fetch_en && (!out_valid || out_ready);
    assign handoff  = out_valid && out_ready;
    assign rom_addr = pc[ADDR_W+1:2];

    fetch_pc_next #(.RESET_PC(RESET_PC)) u_pc_next (
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .load            (load),
        .pc              (pc),
        .pc_next         (pc_next)
    );

    always_ff @(posedge clk) pc <= pc_next;

    // A redirect flushes the wrong-path entry and captures nothing this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_inst     <= NOP_INST;
            out_pc       <= '0;
            out_pc_plus4 <= '0;
        end else if (redirect_valid) begin
            out_valid    <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            out_inst     <= rom_inst;
            out_pc       <= pc;
            out_pc_plus4 <= pc + 32'd4;
        end else if (handoff) begin
            out_valid    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) fetch_count <= '0;
        else if (handoff) fetch_count <= fetch_count + 32'd1;
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed checks of streaming, stalls, redirects, wrap and drain.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic [4:0]  rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic [31:0] fetch_count;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    assign rom_inst = 32'hA000_0000 | {27'd0, rom_addr};

    inst_fetch #(.ADDR_W(5), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .rom_addr        (rom_addr),
        .rom_inst        (rom_inst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .fetch_count     (fetch_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        step(); step();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
        total++; if (fetch_count !== 32'd0) $display("FAIL reset_count got %0d want 0", fetch_count); else passed++;
        total++; if (rom_addr !== 5'd0) $display("FAIL reset_rom_addr got %0d want 0", rom_addr); else passed++;
        total++; if (out_pc !== 32'h0 || out_inst !== 32'h0) $display("FAIL reset_regs got pc %h inst %h want 0 0", out_pc, out_inst); else passed++;
    endtask

    task automatic test_stream();
        rst = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'hA000_0000) $display("FAIL stream0 got v%b pc %h inst %h want v1 0 A0000000", out_valid, out_pc, out_inst); else passed++;
        total++; if (fetch_count !== 32'd0) $display("FAIL stream0_count got %0d want 0", fetch_count); else passed++;
        step();
        total++; if (out_pc !== 32'h4 || out_inst !== 32'hA000_0001 || fetch_count !== 32'd1) $display("FAIL stream1 got pc %h inst %h cnt %0d want 4 A0000001 1", out_pc, out_inst, fetch_count); else passed++;
        step();
        total++; if (out_pc !== 32'h8 || out_inst !== 32'hA000_0002 || fetch_count !== 32'd2) $display("FAIL stream2 got pc %h inst %h cnt %0d want 8 A0000002 2", out_pc, out_inst, fetch_count); else passed++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_pc !== 32'h8 || out_inst !== 32'hA000_0002 || out_pc_plus4 !== 32'hC || rom_addr !== 5'd3 || fetch_count !== 32'd2)
                $display("FAIL stall%0d got v%b pc %h inst %h p4 %h ra %0d cnt %0d want v1 8 A0000002 C 3 2", i, out_valid, out_pc, out_inst, out_pc_plus4, rom_addr, fetch_count);
            else passed++;
        end
        out_ready = 1'b1;
        step();
        total++; if (out_pc !== 32'hC || out_inst !== 32'hA000_0003 || fetch_count !== 32'd3) $display("FAIL stall_release got pc %h inst %h cnt %0d want C A0000003 3", out_pc, out_inst, fetch_count); else passed++;
    endtask

    task automatic test_redirect_stall();
        out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h30;
        step();
        redirect_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || rom_addr !== 5'd12 || fetch_count !== 32'd3) $display("FAIL redir_flush got v%b ra %0d cnt %0d want v0 12 3", out_valid, rom_addr, fetch_count); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h30 || out_inst !== 32'hA000_000C || fetch_count !== 32'd3) $display("FAIL redir_fetch got v%b pc %h inst %h cnt %0d want v1 30 A000000C 3", out_valid, out_pc, out_inst, fetch_count); else passed++;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h7C;
        step();
        redirect_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || fetch_count !== 32'd4 || rom_addr !== 5'd31) $display("FAIL wrap_redir got v%b cnt %0d ra %0d want v0 4 31", out_valid, fetch_count, rom_addr); else passed++;
        step();
        total++; if (out_pc !== 32'h7C || out_inst !== 32'hA000_001F || rom_addr !== 5'd0) $display("FAIL wrap_7c got pc %h inst %h ra %0d want 7C A000001F 0", out_pc, out_inst, rom_addr); else passed++;
        step();
        total++; if (out_pc !== 32'h80 || out_inst !== 32'hA000_0000 || out_pc_plus4 !== 32'h84 || fetch_count !== 32'd5) $display("FAIL wrap_80 got pc %h inst %h p4 %h cnt %0d want 80 A0000000 84 5", out_pc, out_inst, out_pc_plus4, fetch_count); else passed++;
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_target = 32'h33;
        step();
        redirect_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || rom_addr !== 5'd12 || fetch_count !== 32'd6) $display("FAIL misal_redir got v%b ra %0d cnt %0d want v0 12 6", out_valid, rom_addr, fetch_count); else passed++;
        step();
        total++; if (out_pc !== 32'h30 || out_inst !== 32'hA000_000C || out_pc_plus4 !== 32'h34) $display("FAIL misal_fetch got pc %h inst %h p4 %h want 30 A000000C 34", out_pc, out_inst, out_pc_plus4); else passed++;
    endtask

    task automatic test_drain_reset();
        fetch_en = 1'b0;
        step();
        total++; if (out_valid !== 1'b0 || fetch_count !== 32'd7 || rom_addr !== 5'd13) $display("FAIL drain_handoff got v%b cnt %0d ra %0d want v0 7 13", out_valid, fetch_count, rom_addr); else passed++;
        step();
        total++; if (out_valid !== 1'b0 || fetch_count !== 32'd7 || rom_addr !== 5'd13) $display("FAIL drain_hold got v%b cnt %0d ra %0d want v0 7 13", out_valid, fetch_count, rom_addr); else passed++;
        fetch_en = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0 || fetch_count !== 32'd0 || rom_addr !== 5'd0 || out_pc !== 32'h0) $display("FAIL late_reset got v%b cnt %0d ra %0d pc %h want v0 0 0 0", out_valid, fetch_count, rom_addr, out_pc); else passed++;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'hA000_0000) $display("FAIL restart got v%b pc %h inst %h want v1 0 A0000000", out_valid, out_pc, out_inst); else passed++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_stall();
        test_wrap();
        test_misaligned();
        test_drain_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
